// File: rtl/n_bit_sipo_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : n_bit_sipo_deserializer_if
//  Purpose  : Bundles the serial input, the parallel output handshake and the
//             status flags of n_bit_sipo_deserializer.
//  Ports    : i_serial, i_serial_valid, i_clear  - serial side (into block)
//             o_parallel, o_valid, i_ready       - parallel word handshake
//             o_overrun                          - dropped-word pulse
//             o_parity_err                       - only with SIPO_PARITY_EN
//  Modports : slave  - the deserializer itself
//             master - the producer/consumer environment around it
//  Macro    : SIPO_PARITY_EN adds o_parity_err
//  Revision : 1.0 - initial release
// ============================================================================
interface n_bit_sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             i_serial;
    logic             i_serial_valid;
    logic             i_clear;
    logic             i_ready;
    logic [WIDTH-1:0] o_parallel;
    logic             o_valid;
    logic             o_overrun;
`ifdef SIPO_PARITY_EN
    logic             o_parity_err;

    modport slave (
        input  i_serial,
        input  i_serial_valid,
        input  i_clear,
        input  i_ready,
        output o_parallel,
        output o_valid,
        output o_overrun,
        output o_parity_err
    );

    modport master (
        output i_serial,
        output i_serial_valid,
        output i_clear,
        output i_ready,
        input  o_parallel,
        input  o_valid,
        input  o_overrun,
        input  o_parity_err
    );
`else
    modport slave (
        input  i_serial,
        input  i_serial_valid,
        input  i_clear,
        input  i_ready,
        output o_parallel,
        output o_valid,
        output o_overrun
    );

    modport master (
        output i_serial,
        output i_serial_valid,
        output i_clear,
        output i_ready,
        input  o_parallel,
        input  o_valid,
        input  o_overrun
    );
`endif
endinterface
`default_nettype wire

// File: rtl/n_bit_sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : n_bit_sipo_deserializer
//  Purpose  : Serial-in / parallel-out deserializer. Bits arrive LSB first,
//             qualified by i_serial_valid (gaps of any length allowed). A
//             completed word is offered on o_parallel with a valid/ready
//             handshake; a word completing while the previous one is still
//             unaccepted is dropped and flagged with a one-cycle o_overrun.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous reset, active low
//             bus (slave)  - i_serial, i_serial_valid, i_clear, i_ready,
//                            o_parallel, o_valid, o_overrun[, o_parity_err]
//  Params   : WIDTH        - data bits per word (>= 2)
//  Macro    : SIPO_PARITY_EN - each frame carries a trailing even-parity bit;
//                            o_parity_err reports a mismatch per word
//  Revision : 1.0 - initial release
// ============================================================================
module n_bit_sipo_deserializer #(
    parameter int WIDTH = 8
) (
    input  wire                          clk,
    input  wire                          rst,
    n_bit_sipo_deserializer_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SIPO_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [CNT_W-1:0] c_PARITY_CNT = CNT_W'(WIDTH);
`endif

    // Counter value while the last data bit of the word is expected.
    localparam logic [CNT_W-1:0] c_LAST_DATA = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;

    logic [WIDTH-1:0] r_parallel;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_accept;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;
    logic             w_xfer;

    // New bits enter at the top, so after WIDTH shifts the first bit sits in bit 0.
    assign w_shift_next = {bus.i_serial, r_shift[WIDTH-1:1]};

    // A same-edge clear wins: the bit on that edge is thrown away.
    assign w_accept = bus.i_serial_valid & ~bus.i_clear;

    // Consumer handshake only counts when a word is actually held.
    assign w_xfer = r_valid & bus.i_ready;

`ifdef SIPO_PARITY_EN
    logic r_parity_err;
    logic w_parity_err;

    // The parity bit is not shifted in; the word is already complete in r_shift.
    assign w_complete   = w_accept && (r_state == S_PARITY);
    assign w_word       = r_shift;
    // Even parity: data bits XOR parity bit must be zero.
    assign w_parity_err = (^r_shift) ^ bus.i_serial;
    assign bus.o_parity_err = r_parity_err;
`else
    assign w_complete = w_accept && (r_state == S_SHIFT) && (r_cnt == c_LAST_DATA);
    assign w_word     = w_shift_next;
`endif

    // ------------------------------------------------------------------------
    // Frame assembly: state, bit counter and shift register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (bus.i_clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (bus.i_serial_valid) begin
            case (r_state)
                S_IDLE: begin
                    // WIDTH >= 2, so the first bit can never finish a word.
                    r_state <= S_SHIFT;
                    r_cnt   <= c_ONE;
                    r_shift <= w_shift_next;
                end
                S_SHIFT: begin
                    r_shift <= w_shift_next;
                    if (r_cnt == c_LAST_DATA) begin
`ifdef SIPO_PARITY_EN
                        r_state <= S_PARITY;
                        r_cnt   <= c_PARITY_CNT;
`else
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
`ifdef SIPO_PARITY_EN
                S_PARITY: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output word holding register and handshake.
    // A completing word may load when nothing is held or when the held word
    // transfers on this very edge; otherwise it is dropped and flagged.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parallel <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_valid || w_xfer) begin
                    r_parallel <= w_word;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // Parity flag travels with the word it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else if (w_complete && (!r_valid || w_xfer)) begin
            r_parity_err <= w_parity_err;
        end
    end
`endif

    assign bus.o_parallel = r_parallel;
    assign bus.o_valid    = r_valid;
    assign bus.o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: doc/n_bit_sipo_deserializer.md
N_BIT_SIPO_DESERIALIZER -- requirements
Module: n_bit_sipo_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per word (legal WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 i_serial  input  1  serial data bit, LSB first.
REQ-005 i_serial_valid  input  1  i_serial is sampled on this cycle's rising edge when high.
REQ-006 i_clear  input  1  synchronous frame resynchronisation; discards the partial word.
REQ-007 o_parallel  output  WIDTH  last completed word.
REQ-008 o_valid  output  1  o_parallel holds an untransferred word.
REQ-009 i_ready  input  1  consumer accepts o_parallel when o_valid and i_ready are both high at a rising edge.
REQ-010 o_overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-011 o_parity_err  output  1  parity result for the word in o_parallel; present only with the macro in REQ-029.

Function
REQ-012 The block SHALL shift on each edge with i_serial_valid=1: shift_reg <= {i_serial, shift_reg[WIDTH-1:1]}, so the first received bit lands in bit 0.
REQ-013 The block SHALL hold shift_reg and the bit counter unchanged on edges with i_serial_valid=0; gaps of any length are legal.
REQ-014 The bit counter SHALL be $clog2(WIDTH+1) bits wide, count 0..WIDTH-1 (0..WIDTH with parity), and wrap to 0 on the edge that accepts the last bit of a frame.
REQ-015 The FSM SHALL have states IDLE (counter 0, no bits held), SHIFT (1..WIDTH-1 bits held) and, with parity only, PARITY (WIDTH data bits held, awaiting the parity bit).
REQ-016 Transitions SHALL be IDLE->SHIFT on the first accepted bit, SHIFT->IDLE on the WIDTH-th bit (no parity) or SHIFT->PARITY (parity), and PARITY->IDLE on the parity bit.
REQ-017 Word completion SHALL be the edge that accepts the final bit of a frame; on that edge o_parallel loads the assembled word and o_valid sets, both visible the following cycle (latency 1 clock from final-bit sample).
REQ-018 o_valid SHALL stay high and o_parallel stable until a transfer edge (o_valid & i_ready); the transfer clears o_valid unless REQ-020 applies.
REQ-019 On completion while o_valid=1 and i_ready=0, the new word SHALL be dropped, o_parallel and o_valid retained, and o_overrun pulsed high for exactly one cycle.
REQ-020 On completion coinciding with a transfer edge, the new word SHALL load, o_valid SHALL remain 1, and o_overrun SHALL stay 0.
REQ-021 i_clear=1 SHALL return the FSM to IDLE, zero the counter and shift_reg, and take priority over a same-edge i_serial_valid (that bit is discarded); o_parallel, o_valid and a same-edge transfer are unaffected.
REQ-022 i_ready SHALL be ignored while o_valid=0.

Reset
REQ-023 Asserting rst (low) SHALL immediately, without a clock edge, force FSM=IDLE, counter=0, shift_reg=0, o_parallel=0, o_valid=0, o_overrun=0, o_parity_err=0.
REQ-024 Reset mid-word SHALL discard all received bits; the first accepted bit after deassertion starts a new frame.
REQ-025 Deassertion SHALL be released synchronously to clk by the surrounding design; the block samples no input on the deassertion edge beyond normal operation.

Configuration
REQ-026 The macro SIPO_PARITY_EN SHALL select parity support at compile time.
REQ-027 Without SIPO_PARITY_EN: frame = WIDTH bits, no PARITY state, o_parity_err port absent.
REQ-028 With SIPO_PARITY_EN: frame = WIDTH data bits followed by one even-parity bit (XOR of data bits plus parity bit must be 0).
REQ-029 With SIPO_PARITY_EN, o_parity_err SHALL load with o_parallel (1 = parity mismatch), is meaningful only while o_valid=1, and the word is delivered regardless.
REQ-030 Overrun, clear and reset rules SHALL apply identically in both builds, with completion being the parity-bit edge.

Verification
REQ-031 WIDTH=8, no gaps, bits 1,0,1,0,0,1,0,1, i_ready=1 -> o_valid high exactly one cycle after the 8th bit edge, o_parallel=8'hA5, o_overrun=0.
REQ-032 Same word with i_serial_valid low for 3 cycles between bits 4 and 5 -> o_parallel=8'hA5, completion delayed exactly 3 cycles.
REQ-033 i_ready=0, send 8'h3C then 8'hC3 -> o_parallel stays 8'h3C, o_overrun pulses one cycle on 8'hC3 completion; raise i_ready -> o_valid clears next edge.
REQ-034 8'h11 pending, i_ready asserted on the edge completing 8'h22 -> o_parallel=8'h22, o_valid stays 1, o_overrun=0.
REQ-035 Drive rst low after 5 bits, then send 8'hF0 -> all outputs 0 during reset, then o_parallel=8'hF0 with no stale bits; repeat with i_clear=1 after 5 bits -> same result.
REQ-036 SIPO_PARITY_EN, send 8'h07 + parity 1 -> o_parity_err=0; send 8'h07 + parity 0 -> o_parity_err=1, o_parallel=8'h07.
